register_file_ctx: RTL and testbench

//  Parametrised CPU integer register file with N combinational read ports, one write port and a shadow bank for interrupt context.
//  On interrupt entry the main bank is frozen and the handler runs on the shadow bank.
//  On exit, a dirty-tracked restore FSM copies only the registers the handler modified from main back into shadow, one per cycle.

---
 rtl/register_file_ctx.sv | 119 +++++++++++
 tb/tb_register_file_ctx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_ctx.sv
// rtl/register_file_ctx.sv - integer register file with shadow bank for interrupt context and dirty-tracked restore
// Optional write-through read bypass enabled by defining REGFILE_BYPASS_EN.
module register_file_ctx #(
    parameter int  REG_NUM    = 32,
    parameter int  DATA_WIDTH = 64,
    parameter int  READ_PORTS = 2,
    localparam int AW         = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    output logic                           wr_ready,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [READ_PORTS*AW-1:0]       rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                           irq_enter,
    input  logic                           irq_exit,
    output logic                           irq_ready,
    output logic                           in_irq,
    output logic                           busy
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_IRQ     = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [REG_NUM-1:0]      dirty_q, dirty_d;
    logic [DATA_WIDTH-1:0]   main_q   [REG_NUM];
    logic [DATA_WIDTH-1:0]   shadow_q [REG_NUM];
    logic [AW-1:0]           restore_idx;
    logic                    copy_en;
    logic                    wr_fire;

    assign wr_fire = wr_en && wr_ready && (wr_addr != '0);

    // Lowest dirty index wins; bit 0 can never be dirty.
    always_comb begin
        restore_idx = '0;
        for (int i = REG_NUM - 1; i > 0; i--) begin
            if (dirty_q[i]) restore_idx = AW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dirty_d   = dirty_q;
        copy_en   = 1'b0;
        wr_ready  = 1'b1;
        irq_ready = 1'b0;
        in_irq    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                irq_ready = 1'b1;
                if (irq_enter) state_d = ST_IRQ;
            end
            ST_IRQ: begin
                in_irq = 1'b1;
                if (wr_fire) dirty_d[wr_addr] = 1'b1;
                if (irq_exit) state_d = ST_RESTORE;
            end
            ST_RESTORE: begin
                wr_ready = 1'b0;
                busy     = 1'b1;
                if (|dirty_q) begin
                    copy_en              = 1'b1;
                    dirty_d[restore_idx] = 1'b0;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Writes and restore copies never coincide: no write is accepted in RESTORE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                main_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                if (state_q == ST_NORMAL) main_q[wr_addr] <= wr_data;
                shadow_q[wr_addr] <= wr_data;
            end
            if (copy_en) shadow_q[restore_idx] <= main_q[restore_idx];
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [AW-1:0]         ra;
        logic [DATA_WIDTH-1:0] stored;
        assign ra     = rd_addr[p*AW +: AW];
        assign stored = (state_q == ST_IRQ) ? shadow_q[ra] : main_q[ra];
`ifdef REGFILE_BYPASS_EN
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (ra == '0) ? '0 : ((wr_fire && ra == wr_addr) ? wr_data : stored);
`else
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : stored;
`endif
    end

endmodule

// File: tb/tb_register_file_ctx.sv
// tb/tb_register_file_ctx.sv - scoreboard bench for register_file_ctx against a bank-level reference model
module tb_register_file_ctx;
    localparam int RN = 32;
    localparam int DW = 64;
    localparam int RP = 2;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en = 1'b0;
    logic               wr_ready;
    logic [AW-1:0]      wr_addr = '0;
    logic [DW-1:0]      wr_data = '0;
    logic [RP*AW-1:0]   rd_addr = '0;
    logic [RP*DW-1:0]   rd_data;
    logic               irq_enter = 1'b0;
    logic               irq_exit = 1'b0;
    logic               irq_ready;
    logic               in_irq;
    logic               busy;

    register_file_ctx #(.REG_NUM(RN), .DATA_WIDTH(DW), .READ_PORTS(RP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .irq_enter(irq_enter), .irq_exit(irq_exit), .irq_ready(irq_ready),
        .in_irq(in_irq), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic          wr_ready;
        logic          irq_ready;
        logic          in_irq;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: 0 = normal, 1 = handler, 2 = restoring; restore length counted in cycles.
    logic [DW-1:0] m_main   [RN];
    logic [DW-1:0] m_shadow [RN];
    bit            m_dirty  [RN];
    int            m_mode;
    int            m_left;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < RN; i++) begin
            m_main[i] = '0; m_shadow[i] = '0; m_dirty[i] = 0;
        end
        m_mode = 0;
        m_left = 0;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && m_mode != 2 && wa != 0 && wa == a) return wd;
`endif
        return (m_mode == 1) ? m_shadow[a] : m_main[a];
    endfunction

    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input bit ie, input bit ix);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {ra1, ra0};
        irq_enter = ie; irq_exit = ix;
        e.rd0       = model_read(ra0, we, wa, wd);
        e.rd1       = model_read(ra1, we, wa, wd);
        e.wr_ready  = (m_mode != 2);
        e.irq_ready = (m_mode == 0);
        e.in_irq    = (m_mode == 1);
        e.busy      = (m_mode == 2);
        exp_q.push_back(e);
        if (we && m_mode != 2 && wa != 0) begin
            m_shadow[wa] = wd;
            if (m_mode == 0) m_main[wa] = wd;
            else m_dirty[wa] = 1;
        end
        case (m_mode)
            0: if (ie) m_mode = 1;
            1: if (ix) begin
                d = 0;
                for (int i = 0; i < RN; i++) if (m_dirty[i]) d++;
                m_mode = 2;
                m_left = d + 1;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0;
                    for (int i = 0; i < RN; i++) begin
                        m_shadow[i] = m_main[i]; m_dirty[i] = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(0, '0, '0, ra0, ra1, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("rd0", rd_data[DW-1:0], mon_e.rd0);
            chk("rd1", rd_data[2*DW-1:DW], mon_e.rd1);
            chk("wr_ready", DW'(wr_ready), DW'(mon_e.wr_ready));
            chk("irq_ready", DW'(irq_ready), DW'(mon_e.irq_ready));
            chk("in_irq", DW'(in_irq), DW'(mon_e.in_irq));
            chk("busy", DW'(busy), DW'(mon_e.busy));
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, RN - 1));
    endfunction

    initial begin
        reset = 1'b1;
        model_reset();
        #2;
        chk("reset_rd", rd_data[DW-1:0], '0);
        chk("reset_wr_ready", DW'(wr_ready), 64'd1);
        chk("reset_irq_ready", DW'(irq_ready), 64'd1);
        chk("reset_busy", DW'(busy), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        drive(1, 5, 64'hDEAD, 5, 0, 0, 0);
        drive(1, 0, 64'h1, 5, 0, 0, 0);
        idle(5, 0);
        drive(1, 7, 64'h1234, 0, 7, 0, 0);
        idle(5, 7);

        drive(1, 3, 64'hAA, 3, 0, 0, 0);
        drive(0, 0, '0, 3, 0, 1, 0);
        drive(1, 3, 64'hBB, 3, 3, 0, 0);
        drive(0, 0, '0, 3, 0, 0, 1);
        repeat (3) idle(3, 0);

        drive(0, 0, '0, 1, 2, 1, 0);
        drive(1, 1, 64'h11, 1, 2, 0, 0);
        drive(1, 2, 64'h22, 2, 31, 0, 0);
        drive(1, 31, 64'h3131, 31, 1, 0, 0);
        drive(1, 2, 64'h2222, 2, 9, 0, 1);
        repeat (6) drive(1, 9, 64'h55, 9, 2, 0, 0);
        idle(9, 2);

        drive(1, 4, 64'h44, 4, 0, 1, 1);
        drive(1, 4, 64'h4444, 4, 9, 0, 0);
        drive(1, 6, 64'h66, 6, 4, 0, 1);
        repeat (5) drive(0, 0, '0, 4, 6, 1, 0);
        drive(1, 8, 64'h88, 8, 4, 0, 0);
        drive(0, 0, '0, 8, 4, 0, 1);
        repeat (6) idle(4, 8);

        drive(0, 0, '0, 5, 7, 1, 0);
        drive(1, 10, 64'hA0, 5, 7, 0, 0);
        drive(1, 11, 64'hB0, 5, 7, 0, 0);
        drive(1, 12, 64'hC0, 5, 7, 0, 1);
        idle(5, 7);
        #6 reset = 1'b1;
        #1;
        chk("mid_restore_rst_busy", DW'(busy), 64'd0);
        chk("mid_restore_rst_irq_ready", DW'(irq_ready), 64'd1);
        chk("mid_restore_rst_rd0", rd_data[DW-1:0], '0);
        chk("mid_restore_rst_rd1", rd_data[2*DW-1:DW], '0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        idle(5, 7);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 1) == 1, rnd_addr(), {$urandom, $urandom},
                  rnd_addr(), rnd_addr(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
